// File: rtl/ibr128_pkg.sv
// Shared types and constants for the IBR128 mode-of-operation sequencer.
package ibr128_pkg;

    localparam int BLK_W = 128;

    // Chaining mode encoding as seen on cfg_mode.
    typedef enum logic [1:0] {
        SOM_ECB = 2'b00,
        SOM_CBC = 2'b01,
        SOM_CFB = 2'b10,
        SOM_OFB = 2'b11
    } som_e;

    // Sequencer states: one block in flight at a time.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_WAIT  = 2'b10,
        ST_OUT   = 2'b11
    } seq_state_e;

endpackage

// File: rtl/ibr128_chain_unit.sv
// Combinational chaining datapath: selects the core input, the result block and
// the next chaining value for the latched mode and direction.
module ibr128_chain_unit
    import ibr128_pkg::*;
(
    input  logic [1:0]       mode,
    input  logic             encrypt,
    input  logic [BLK_W-1:0] blk,
    input  logic [BLK_W-1:0] chain,
    input  logic [BLK_W-1:0] core_dout,
    output logic [BLK_W-1:0] core_din,
    output logic             core_encrypt,
    output logic [BLK_W-1:0] out_blk,
    output logic [BLK_W-1:0] next_chain
);

    som_e mode_e;
    assign mode_e = som_e'(mode);

    // Mode table: CFB and OFB always run the core forward on the chain value.
    always_comb begin
        core_din     = blk;
        core_encrypt = encrypt;
        out_blk      = core_dout;
        next_chain   = chain;
        case (mode_e)
            SOM_ECB: begin
                core_din     = blk;
                core_encrypt = encrypt;
                out_blk      = core_dout;
                next_chain   = chain;
            end
            SOM_CBC: begin
                if (encrypt) begin
                    core_din     = blk ^ chain;
                    core_encrypt = 1'b1;
                    out_blk      = core_dout;
                    next_chain   = core_dout;
                end else begin
                    core_din     = blk;
                    core_encrypt = 1'b0;
                    out_blk      = core_dout ^ chain;
                    next_chain   = blk;
                end
            end
            SOM_CFB: begin
                core_din     = chain;
                core_encrypt = 1'b1;
                out_blk      = core_dout ^ blk;
                // Feedback is always the ciphertext: our output when encrypting, the input when decrypting.
                next_chain   = encrypt ? (core_dout ^ blk) : blk;
            end
            SOM_OFB: begin
                core_din     = chain;
                core_encrypt = 1'b1;
                out_blk      = core_dout ^ blk;
                next_chain   = core_dout;
            end
            default: begin
                core_din     = blk;
                core_encrypt = encrypt;
                out_blk      = core_dout;
                next_chain   = chain;
            end
        endcase
    end

endmodule

// File: rtl/ibr128_mode_seq.sv
// Streaming ECB/CBC/CFB/OFB sequencer in front of the IBR128 core. One block in
// flight; the chain value is only advanced when the core actually returns a result.
module ibr128_mode_seq
    import ibr128_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024,
    parameter int CNT_W       = 32
) (
    input  logic               Clk,
    input  logic               RstN,
    input  logic               cfg_enable,
    input  logic [1:0]         cfg_mode,
    input  logic               cfg_encrypt,
    input  logic [BLK_W-1:0]   cfg_iv,
    input  logic               cfg_iv_load,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLK_W-1:0]   in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLK_W-1:0]   out_data,
    output logic               core_start,
    output logic               core_encrypt,
    output logic [BLK_W-1:0]   core_din,
    input  logic               core_done,
    input  logic [BLK_W-1:0]   core_dout,
    output logic               busy,
    output logic [CNT_W-1:0]   blk_count,
    output logic               err_timeout,
    output logic               err_ivdrop
);

    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    // Counter value on the last permitted WAIT cycle.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    seq_state_e       state_q, state_d;
    logic [BLK_W-1:0] blk_q, blk_d;
    som_e             mode_q, mode_d;
    logic             enc_q, enc_d;
    logic [BLK_W-1:0] chain_q, chain_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [BLK_W-1:0] out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             core_start_q, core_start_d;
    logic [CNT_W-1:0] blk_count_q, blk_count_d;
    logic             err_timeout_q, err_timeout_d;
    logic             err_ivdrop_q, err_ivdrop_d;

    logic [BLK_W-1:0] out_blk;
    logic [BLK_W-1:0] next_chain;

    ibr128_chain_unit u_chain (
        .mode         (mode_q),
        .encrypt      (enc_q),
        .blk          (blk_q),
        .chain        (chain_q),
        .core_dout    (core_dout),
        .core_din     (core_din),
        .core_encrypt (core_encrypt),
        .out_blk      (out_blk),
        .next_chain   (next_chain)
    );

    // An IV load in the same cycle blocks capture so the new chain applies to the next block.
    assign in_ready    = (state_q == ST_IDLE) & cfg_enable & ~cfg_iv_load;
    assign busy        = (state_q != ST_IDLE);
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign core_start  = core_start_q;
    assign blk_count   = blk_count_q;
    assign err_timeout = err_timeout_q;
    assign err_ivdrop  = err_ivdrop_q;

    // Next-state logic for the sequencer FSM and all registered outputs.
    always_comb begin
        state_d       = state_q;
        blk_d         = blk_q;
        mode_d        = mode_q;
        enc_d         = enc_q;
        chain_d       = chain_q;
        tmo_d         = tmo_q;
        out_data_d    = out_data_q;
        out_valid_d   = out_valid_q;
        core_start_d  = 1'b0;
        blk_count_d   = blk_count_q;
        err_timeout_d = err_timeout_q;
        err_ivdrop_d  = err_ivdrop_q;
        case (state_q)
            ST_IDLE: begin
                if (cfg_iv_load) begin
                    chain_d       = cfg_iv;
                    blk_count_d   = '0;
                    err_timeout_d = 1'b0;
                    err_ivdrop_d  = 1'b0;
                end else if (in_valid && in_ready) begin
                    blk_d        = in_data;
                    mode_d       = som_e'(cfg_mode);
                    enc_d        = cfg_encrypt;
                    core_start_d = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_d   = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done) begin
                    out_data_d  = out_blk;
                    chain_d     = next_chain;
                    out_valid_d = 1'b1;
                    state_d     = ST_OUT;
                end else if (tmo_q == TMO_LAST) begin
                    // Drop the block; the chain keeps its pre-block value.
                    err_timeout_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    blk_count_d = blk_count_q + CNT_W'(1);
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (cfg_iv_load && (state_q != ST_IDLE)) begin
            err_ivdrop_d = 1'b1;
        end
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state_q       <= ST_IDLE;
            blk_q         <= '0;
            mode_q        <= SOM_ECB;
            enc_q         <= 1'b0;
            chain_q       <= '0;
            tmo_q         <= '0;
            out_data_q    <= '0;
            out_valid_q   <= 1'b0;
            core_start_q  <= 1'b0;
            blk_count_q   <= '0;
            err_timeout_q <= 1'b0;
            err_ivdrop_q  <= 1'b0;
        end else begin
            state_q       <= state_d;
            blk_q         <= blk_d;
            mode_q        <= mode_d;
            enc_q         <= enc_d;
            chain_q       <= chain_d;
            tmo_q         <= tmo_d;
            out_data_q    <= out_data_d;
            out_valid_q   <= out_valid_d;
            core_start_q  <= core_start_d;
            blk_count_q   <= blk_count_d;
            err_timeout_q <= err_timeout_d;
            err_ivdrop_q  <= err_ivdrop_d;
        end
    end

endmodule

// File: tb/tb_ibr128_mode_seq.sv
// Self-checking bench for ibr128_mode_seq: directed scenarios plus randomized
// blocks compared against a mode-table reference model and a fixed-latency core model.
module tb_ibr128_mode_seq;

    localparam int CW = 4;
    localparam logic [127:0] K = {4{32'hA5A5_5A5A}};

    logic           Clk = 1'b0;
    logic           RstN = 1'b0;
    logic           cfg_enable = 1'b0;
    logic [1:0]     cfg_mode = 2'd0;
    logic           cfg_encrypt = 1'b0;
    logic [127:0]   cfg_iv = '0;
    logic           cfg_iv_load = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [127:0]   in_data = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [127:0]   out_data;
    logic           core_start;
    logic           core_encrypt;
    logic [127:0]   core_din;
    logic           core_done = 1'b0;
    logic [127:0]   core_dout = '0;
    logic           busy;
    logic [CW-1:0]  blk_count;
    logic           err_timeout;
    logic           err_ivdrop;

    int errors = 0;
    int checks = 0;

    // Core model state
    logic         core_en = 1'b1;
    int           core_cnt = 0;
    logic [127:0] cap_din = '0;
    logic [127:0] cap_res = '0;
    logic         cap_enc = 1'b0;

    // Reference model state
    logic [127:0] m_chain = '0;
    int           m_count = 0;

    ibr128_mode_seq #(.TIMEOUT_CYC(8), .CNT_W(CW)) dut (
        .Clk(Clk), .RstN(RstN), .cfg_enable(cfg_enable), .cfg_mode(cfg_mode),
        .cfg_encrypt(cfg_encrypt), .cfg_iv(cfg_iv), .cfg_iv_load(cfg_iv_load),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .core_start(core_start), .core_encrypt(core_encrypt), .core_din(core_din),
        .core_done(core_done), .core_dout(core_dout), .busy(busy),
        .blk_count(blk_count), .err_timeout(err_timeout), .err_ivdrop(err_ivdrop)
    );

    always #5 Clk = ~Clk;

    // Core: d = din ^ K, done pulse three cycles after the start cycle.
    always @(negedge Clk) begin
        core_done = 1'b0;
        if (core_cnt > 0) begin
            core_cnt = core_cnt - 1;
            if (core_cnt == 0) begin
                core_done = 1'b1;
                core_dout = cap_res;
            end
        end
        if (core_start && core_en) begin
            cap_din  = core_din;
            cap_enc  = core_encrypt;
            cap_res  = core_din ^ K;
            core_cnt = 3;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Mode table from the block's definition of ECB/CBC/CFB/OFB.
    function automatic void ref_step(input logic [1:0] m, input logic e,
                                     input logic [127:0] b, input logic [127:0] c,
                                     output logic [127:0] din, output logic xe,
                                     output logic [127:0] o, output logic [127:0] nc);
        logic [127:0] d;
        if (m == 2'd0)      begin din = b; xe = e; end
        else if (m == 2'd1) begin din = e ? (b ^ c) : b; xe = e; end
        else                begin din = c; xe = 1'b1; end
        d = din ^ K;
        if (m == 2'd0)      begin o = d; nc = c; end
        else if (m == 2'd1) begin o = e ? d : (d ^ c); nc = e ? d : b; end
        else if (m == 2'd2) begin o = d ^ b; nc = e ? (d ^ b) : b; end
        else                begin o = d ^ b; nc = d; end
    endfunction

    task automatic do_ivload(input logic [127:0] iv);
        @(negedge Clk);
        cfg_iv = iv;
        cfg_iv_load = 1'b1;
        @(negedge Clk);
        cfg_iv_load = 1'b0;
        m_chain = iv;
        m_count = 0;
        chk("ivload_count", 128'(blk_count), 128'(0));
        chk1("ivload_clr_tmo", err_timeout, 1'b0);
        chk1("ivload_clr_ivdrop", err_ivdrop, 1'b0);
    endtask

    // One full block: capture, core op, output with bp cycles of backpressure.
    task automatic do_block(input logic [1:0] m, input logic e, input logic [127:0] b,
                            input int bp, input bit ivw);
        logic [127:0] xdin, xo, xnc;
        logic         xe;
        int           n;
        ref_step(m, e, b, m_chain, xdin, xe, xo, xnc);
        @(negedge Clk);
        cfg_mode = m; cfg_encrypt = e; in_data = b; in_valid = 1'b1;
        #1;
        chk1("in_ready_idle", in_ready, 1'b1);
        @(negedge Clk);
        // Scramble config/data after capture: must not affect the block in flight.
        in_valid = 1'b0;
        in_data = {4{$urandom}};
        cfg_mode = 2'($urandom);
        cfg_encrypt = 1'($urandom);
        cfg_enable = 1'($urandom);
        n = 0;
        if (ivw) begin
            @(negedge Clk);
            cfg_iv = {4{$urandom}};
            cfg_iv_load = 1'b1;
            @(negedge Clk);
            cfg_iv_load = 1'b0;
            n = 2;
        end
        while (!out_valid && n < 50) begin
            @(negedge Clk);
            n++;
        end
        chk("latency", 128'(n), 128'(4));
        if (ivw) chk1("ivdrop_set", err_ivdrop, 1'b1);
        chk("core_din", cap_din, xdin);
        chk1("core_enc", cap_enc, xe);
        chk("out_data", out_data, xo);
        for (int i = 0; i < bp; i++) begin
            @(negedge Clk);
            in_valid = 1'b1;
            in_data = {4{$urandom}};
            #1;
            chk1("bp_valid", out_valid, 1'b1);
            chk("bp_data", out_data, xo);
            chk1("bp_in_ready", in_ready, 1'b0);
        end
        @(negedge Clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge Clk);
        out_ready = 1'b0;
        cfg_enable = 1'b1;
        m_chain = xnc;
        m_count = (m_count + 1) % (1 << CW);
        chk1("out_released", out_valid, 1'b0);
        chk("blk_count", 128'(blk_count), 128'(m_count));
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge Clk);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_core_start", core_start, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b0);
        chk("rst_count", 128'(blk_count), 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        chk1("rst_err_tmo", err_timeout, 1'b0);
        chk1("rst_err_iv", err_ivdrop, 1'b0);
        RstN = 1'b1;
        cfg_enable = 1'b1;

        // ECB single block, then CBC-enc from iv 0xF0, then OFB from iv 0
        do_block(2'd0, 1'b1, 128'h1, 0, 1'b0);
        do_ivload(128'hF0);
        do_block(2'd1, 1'b1, 128'h01, 0, 1'b0);
        do_block(2'd1, 1'b1, 128'h02, 0, 1'b0);
        do_ivload(128'h0);
        do_block(2'd3, 1'b1, {4{$urandom}}, 0, 1'b0);
        do_block(2'd3, 1'b0, {4{$urandom}}, 0, 1'b0);

        // Ten cycles of output backpressure
        do_block(2'd2, 1'b1, {4{$urandom}}, 10, 1'b0);

        // IV load and in_valid together in IDLE: load wins, nothing captured
        @(negedge Clk);
        cfg_iv = {4{$urandom}};
        cfg_iv_load = 1'b1;
        in_valid = 1'b1;
        in_data = {4{$urandom}};
        #1;
        chk1("ivload_blocks_ready", in_ready, 1'b0);
        @(negedge Clk);
        cfg_iv_load = 1'b0;
        in_valid = 1'b0;
        m_chain = cfg_iv;
        m_count = 0;
        #1;
        chk1("ivload_no_capture", busy, 1'b0);
        chk("ivload_cnt", 128'(blk_count), 128'(0));
        do_block(2'd1, 1'b1, {4{$urandom}}, 1, 1'b0);

        // IV load during WAIT: flagged, chain kept, cleared by the next honoured load
        do_block(2'd1, 1'b1, {4{$urandom}}, 0, 1'b1);
        do_block(2'd1, 1'b0, {4{$urandom}}, 0, 1'b0);
        chk1("ivdrop_sticky", err_ivdrop, 1'b1);
        do_ivload({4{$urandom}});

        // Disabled: no acceptance
        @(negedge Clk);
        cfg_enable = 1'b0;
        in_valid = 1'b1;
        #1;
        chk1("disabled_ready", in_ready, 1'b0);
        @(negedge Clk);
        chk1("disabled_idle", busy, 1'b0);
        in_valid = 1'b0;
        cfg_enable = 1'b1;

        // Timeout: core never answers
        do_block(2'd0, 1'b0, {4{$urandom}}, 0, 1'b0);
        core_en = 1'b0;
        @(negedge Clk);
        cfg_mode = 2'd1; cfg_encrypt = 1'b1; in_data = {4{$urandom}}; in_valid = 1'b1;
        @(negedge Clk);
        in_valid = 1'b0;
        repeat (8) @(negedge Clk);
        chk1("tmo_still_wait", busy, 1'b1);
        chk1("tmo_not_yet", err_timeout, 1'b0);
        @(negedge Clk);
        chk1("tmo_idle", busy, 1'b0);
        chk1("tmo_flag", err_timeout, 1'b1);
        chk1("tmo_no_out", out_valid, 1'b0);
        chk("tmo_count", 128'(blk_count), 128'(m_count));
        core_en = 1'b1;
        // Chain must be untouched by the dropped block
        do_block(2'd1, 1'b1, {4{$urandom}}, 0, 1'b0);
        chk1("tmo_sticky", err_timeout, 1'b1);
        do_ivload({4{$urandom}});

        // Randomized traffic; count wraps past 2^CW
        for (int k = 0; k < 30; k++) begin
            if ($urandom_range(0, 5) == 0) do_ivload({4{$urandom}});
            do_block(2'($urandom), 1'($urandom), {4{$urandom}}, int'($urandom_range(0, 3)), 1'b0);
        end

        // Reset while waiting on the core
        @(negedge Clk);
        cfg_mode = 2'd0; in_data = {4{$urandom}}; in_valid = 1'b1;
        @(negedge Clk);
        in_valid = 1'b0;
        @(negedge Clk);
        RstN = 1'b0;
        #1;
        chk1("arst_busy", busy, 1'b0);
        chk1("arst_core_start", core_start, 1'b0);
        chk1("arst_out_valid", out_valid, 1'b0);
        chk("arst_count", 128'(blk_count), 128'(0));
        chk("arst_out_data", out_data, 128'(0));
        @(negedge Clk);
        RstN = 1'b1;
        // A late core_done lands in IDLE and must be ignored
        repeat (5) @(negedge Clk);
        chk1("late_done_idle", busy, 1'b0);
        chk1("late_done_no_out", out_valid, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
